// File: rtl/secure_mem_access_ctrl.sv
// secure_mem_access_ctrl
// Key-gated access controller with a RAM region and a one-time-programmable
// ROM region. Each accepted request is checked against RAM_KEY / ROM_KEY,
// performed, and answered with a one-cycle response strobe. MAX_FAIL
// consecutive bad keys lock out all requests for LOCK_CYCLES cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req_*      single-beat request (valid/ready handshake, write, key, addr, wdata)
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data, 0 for writes and errors; held until the next response
//   rsp_err    00 OK, 01 bad key, 10 ROM byte already programmed
//   locked     lockout active
//   fail_cnt   consecutive bad-key count (saturates at MAX_FAIL)
//
// Optional feature (macro ACCESS_AUDIT_EN):
//   audit_fail_total  saturating count of every bad-key attempt since reset.

module secure_mem_access_ctrl #(
    parameter int unsigned AW          = 4,
    parameter logic [7:0]  RAM_KEY     = 8'hBF,
    parameter logic [7:0]  ROM_KEY     = 8'h3E,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [7:0]    req_key,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    output logic          rsp_valid,
    output logic [7:0]    rsp_rdata,
    output logic [1:0]    rsp_err,
    output logic          locked,
    output logic [1:0]    fail_cnt
`ifdef ACCESS_AUDIT_EN
    ,
    output logic [7:0]    audit_fail_total
`endif
);

    localparam int unsigned     Depth    = 2 ** AW;
    localparam int unsigned     CntW     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [1:0]      MaxFail  = 2'(MAX_FAIL);
    localparam logic [CntW-1:0] LockLoad = CntW'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCheck, StResp, StLockout} state_e;

    state_e          state_q, state_d;
    logic            wr_q, wr_d;
    logic [7:0]      key_q, key_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;
    logic [1:0]      fail_q, fail_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic [7:0]      ram_q [Depth];
    logic [7:0]      ram_d [Depth];
    logic [7:0]      rom_q [Depth];
    logic [7:0]      rom_d [Depth];
    logic [Depth-1:0] prog_q, prog_d;
`ifdef ACCESS_AUDIT_EN
    logic [7:0]      audit_q, audit_d;
`endif

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        key_d      = key_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        fail_d     = fail_q;
        lock_cnt_d = lock_cnt_q;
        ram_d      = ram_q;
        rom_d      = rom_q;
        prog_d     = prog_q;
`ifdef ACCESS_AUDIT_EN
        audit_d    = audit_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    key_d   = req_key;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                rdata_d = 8'h00;
                err_d   = 2'b00;
                state_d = StResp;
                if (key_q == RAM_KEY) begin
                    fail_d = 2'd0;
                    if (wr_q) ram_d[addr_q] = wdata_q;
                    else      rdata_d = ram_q[addr_q];
                end else if (key_q == ROM_KEY) begin
                    // A rejected re-program still proves the key, so it clears fail_cnt.
                    fail_d = 2'd0;
                    if (wr_q) begin
                        if (prog_q[addr_q]) begin
                            err_d = 2'b10;
                        end else begin
                            rom_d[addr_q]  = wdata_q;
                            prog_d[addr_q] = 1'b1;
                        end
                    end else begin
                        rdata_d = rom_q[addr_q];
                    end
                end else begin
                    err_d = 2'b01;
                    if (fail_q != MaxFail) fail_d = fail_q + 2'd1;
`ifdef ACCESS_AUDIT_EN
                    if (audit_q != 8'hFF) audit_d = audit_q + 8'd1;
`endif
                end
            end
            StResp: begin
                if (fail_q == MaxFail) begin
                    state_d    = StLockout;
                    lock_cnt_d = LockLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StLockout: begin
                if (lock_cnt_q == '0) begin
                    state_d = StIdle;
                    fail_d  = 2'd0;
                end else begin
                    lock_cnt_d = lock_cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            wr_q       <= 1'b0;
            key_q      <= 8'h00;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
            err_q      <= 2'b00;
            fail_q     <= 2'd0;
            lock_cnt_q <= '0;
            prog_q     <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                ram_q[i] <= 8'h00;
                rom_q[i] <= 8'h00;
            end
`ifdef ACCESS_AUDIT_EN
            audit_q    <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            key_q      <= key_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            fail_q     <= fail_d;
            lock_cnt_q <= lock_cnt_d;
            prog_q     <= prog_d;
            ram_q      <= ram_d;
            rom_q      <= rom_d;
`ifdef ACCESS_AUDIT_EN
            audit_q    <= audit_d;
`endif
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign locked    = (state_q == StLockout);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign fail_cnt  = fail_q;
`ifdef ACCESS_AUDIT_EN
    assign audit_fail_total = audit_q;
`endif

endmodule

// File: tb/tb_secure_mem_access_ctrl.sv
// Directed self-checking bench for secure_mem_access_ctrl (default parameters).
module tb_secure_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_key = 8'h00;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;
    logic       locked;
    logic [1:0] fail_cnt;
`ifdef ACCESS_AUDIT_EN
    logic [7:0] audit_fail_total;
`endif

    int checks = 0;
    int errors = 0;

    secure_mem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_key   (req_key),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .locked    (locked),
        .fail_cnt  (fail_cnt)
`ifdef ACCESS_AUDIT_EN
        ,
        .audit_fail_total (audit_fail_total)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge with the request already driven and accepted at the
    // coming posedge (E0). Checks strobe timing and returns the response.
    task automatic finish_req(output logic [7:0] rd, output logic [1:0] er);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);  // between E0 and E1: CHECK
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rsp_early got %b want 0", rsp_valid);
        end
        @(negedge clk);  // between E1 and E2: RESP
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rsp_strobe got %b want 1", rsp_valid);
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);  // after E2
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== rd || rsp_err !== er) begin
            errors++;
            $display("FAIL rsp_hold got v=%b d=%h e=%b want v=0 d=%h e=%b",
                     rsp_valid, rsp_rdata, rsp_err, rd, er);
        end
    endtask

    task automatic do_req(input logic w, input logic [7:0] k, input logic [3:0] a,
                          input logic [7:0] d, output logic [7:0] rd, output logic [1:0] er);
        int waited;
        @(negedge clk);
        req_write = w; req_key = k; req_addr = a; req_wdata = d; req_valid = 1'b1;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL accept_timeout got ready=%b want 1", req_ready);
            req_valid = 1'b0;
            rd = 8'hxx; er = 2'bxx;
        end else begin
            finish_req(rd, er);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 ||
            rsp_err !== 2'b00 || locked !== 1'b0 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b d=%h e=%b l=%b f=%0d want 1 0 00 00 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, locked, fail_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ram();
        logic [7:0] rd; logic [1:0] er;
        do_req(1'b1, 8'hBF, 4'd3, 8'h5A, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h00) begin
            errors++; $display("FAIL ram_write got d=%h e=%b want 00 00", rd, er);
        end
        do_req(1'b0, 8'hBF, 4'd3, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h5A) begin
            errors++; $display("FAIL ram_read got d=%h e=%b want 5a 00", rd, er);
        end
    endtask

    task automatic test_rom();
        logic [7:0] rd; logic [1:0] er;
        do_req(1'b1, 8'h3E, 4'd7, 8'hC3, rd, er);
        checks++;
        if (er !== 2'b00) begin
            errors++; $display("FAIL rom_prog got e=%b want 00", er);
        end
        do_req(1'b1, 8'h3E, 4'd7, 8'h11, rd, er);
        checks++;
        if (er !== 2'b10 || rd !== 8'h00 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rom_reprog got d=%h e=%b f=%0d want 00 10 0", rd, er, fail_cnt);
        end
        do_req(1'b0, 8'h3E, 4'd7, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'hC3 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rom_read got d=%h e=%b f=%0d want c3 00 0", rd, er, fail_cnt);
        end
        // Same address in RAM is a separate array.
        do_req(1'b0, 8'hBF, 4'd7, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h00) begin
            errors++; $display("FAIL region_indep got d=%h e=%b want 00 00", rd, er);
        end
    endtask

    task automatic test_bad_key();
        logic [7:0] rd; logic [1:0] er;
        do_req(1'b0, 8'h00, 4'd3, 8'h00, rd, er);
        checks++;
        if (er !== 2'b01 || rd !== 8'h00 || fail_cnt !== 2'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bad1 got d=%h e=%b f=%0d l=%b want 00 01 1 0", rd, er, fail_cnt, locked);
        end
        do_req(1'b1, 8'h00, 4'd3, 8'hEE, rd, er);
        checks++;
        if (er !== 2'b01 || fail_cnt !== 2'd2 || locked !== 1'b0) begin
            errors++;
            $display("FAIL bad2 got e=%b f=%0d l=%b want 01 2 0", er, fail_cnt, locked);
        end
        do_req(1'b0, 8'hBF, 4'd3, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h5A || fail_cnt !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL good_clears got d=%h e=%b f=%0d l=%b want 5a 00 0 0",
                     rd, er, fail_cnt, locked);
        end
        // A rejected ROM re-program also clears the count.
        do_req(1'b0, 8'h3F, 4'd0, 8'h00, rd, er);
        do_req(1'b1, 8'h3E, 4'd7, 8'h22, rd, er);
        checks++;
        if (er !== 2'b10 || fail_cnt !== 2'd0) begin
            errors++; $display("FAIL reprog_clears got e=%b f=%0d want 10 0", er, fail_cnt);
        end
    endtask

    task automatic test_lockout();
        logic [7:0] rd; logic [1:0] er;
        int lock_len;
        int rdy_bad;
        do_req(1'b0, 8'h01, 4'd0, 8'h00, rd, er);
        do_req(1'b0, 8'h02, 4'd0, 8'h00, rd, er);
        do_req(1'b0, 8'hBE, 4'd0, 8'h00, rd, er);
        checks++;
        if (er !== 2'b01 || fail_cnt !== 2'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_enter got e=%b f=%0d l=%b want 01 3 1", er, fail_cnt, locked);
        end
        // Hold a valid RAM read throughout the lockout.
        req_write = 1'b0; req_key = 8'hBF; req_addr = 4'd3; req_wdata = 8'h00;
        req_valid = 1'b1;
        lock_len = 0;
        rdy_bad = 0;
        while (locked === 1'b1 && lock_len < 40) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) rdy_bad++;
            lock_len++;
            @(negedge clk);
        end
        checks++;
        if (lock_len != 16) begin
            errors++; $display("FAIL lock_len got %0d want 16", lock_len);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++; $display("FAIL lock_ready got %0d cycles ready/rsp want 0", rdy_bad);
        end
        checks++;
        if (req_ready !== 1'b1 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL lock_exit got rdy=%b f=%0d want 1 0", req_ready, fail_cnt);
        end
        finish_req(rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h5A || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL held_req got d=%h e=%b f=%0d want 5a 00 0", rd, er, fail_cnt);
        end
    endtask

    task automatic test_reset_in_check();
        logic [7:0] rd; logic [1:0] er;
        // Leave a nonzero response and fail count so reset has something to clear.
        do_req(1'b0, 8'h00, 4'd0, 8'h00, rd, er);
        @(negedge clk);
        req_write = 1'b1; req_key = 8'hBF; req_addr = 4'd2; req_wdata = 8'h99;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 rst = 1'b0;  // in CHECK, before E1
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 ||
            rsp_err !== 2'b00 || locked !== 1'b0 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rst_async got rdy=%b v=%b d=%h e=%b l=%b f=%0d want 1 0 00 00 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, locked, fail_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 ||
            rsp_err !== 2'b00 || locked !== 1'b0 || fail_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rst_hold got rdy=%b v=%b d=%h e=%b l=%b f=%0d want 1 0 00 00 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, locked, fail_cnt);
        end
        rst = 1'b1;
        do_req(1'b0, 8'hBF, 4'd2, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h00) begin
            errors++; $display("FAIL rst_abort_write got d=%h e=%b want 00 00", rd, er);
        end
        // ROM programmed bits were cleared: addr 7 can be programmed again.
        do_req(1'b1, 8'h3E, 4'd7, 8'h44, rd, er);
        do_req(1'b0, 8'h3E, 4'd7, 8'h00, rd, er);
        checks++;
        if (er !== 2'b00 || rd !== 8'h44) begin
            errors++; $display("FAIL rst_rom_clear got d=%h e=%b want 44 00", rd, er);
        end
    endtask

`ifdef ACCESS_AUDIT_EN
    task automatic test_audit();
        logic [7:0] rd; logic [1:0] er;
        int guard;
        for (int i = 0; i < 3; i++) do_req(1'b0, 8'h55, 4'd0, 8'h00, rd, er);
        guard = 0;
        while (locked === 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL audit_lock_timeout got l=%b want 0", locked);
        end
        do_req(1'b0, 8'h55, 4'd0, 8'h00, rd, er);
        checks++;
        if (audit_fail_total !== 8'd4 || fail_cnt !== 2'd1) begin
            errors++;
            $display("FAIL audit_total got a=%0d f=%0d want 4 1", audit_fail_total, fail_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ram();
        test_rom();
        test_bad_key();
        test_lockout();
        test_reset_in_check();
`ifdef ACCESS_AUDIT_EN
        test_audit();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
